// File: rtl/combo_bist_ctrl_pkg.sv
// Shared constants and state encoding for the combo_bist_ctrl truth-table sequencer.
package combo_bist_pkg;

  localparam int N_IN_DEF = 5;
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/combo_bist_ctrl_if.sv
// Bundle between the sweep sequencer and its environment (gate under test plus control).
// With COMBO_BIST_FAILIDX_EN defined, the first-failure capture signals are added.
interface combo_bist_ctrl_if import combo_bist_pkg::*; #(
  parameter int N_IN = N_IN_DEF
);

  logic                   start;
  logic                   abort;
  logic                   z;
  logic [N_IN-1:0]        vec;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   tt;
  logic [N_IN:0]          fail_cnt;
`ifdef COMBO_BIST_FAILIDX_EN
  logic [N_IN-1:0]        fail_idx;
  logic                   fail_seen;

  modport master (
    input  start, abort, z,
    output vec, busy, done, pass, tt, fail_cnt, fail_idx, fail_seen
  );

  modport slave (
    output start, abort, z,
    input  vec, busy, done, pass, tt, fail_cnt, fail_idx, fail_seen
  );
`else
  modport master (
    input  start, abort, z,
    output vec, busy, done, pass, tt, fail_cnt
  );

  modport slave (
    output start, abort, z,
    input  vec, busy, done, pass, tt, fail_cnt
  );
`endif

endinterface

// File: rtl/combo_bist_ctrl_settle_cnt.sv
// Loadable down-counter timing the settle window between a vector update and the z sample.
module combo_bist_settle_cnt import combo_bist_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/combo_bist_ctrl.sv
// Exhaustive truth-table sweep of a small combinational gate against a golden table.
// Optional first-failure capture (fail_idx/fail_seen) is enabled by COMBO_BIST_FAILIDX_EN.
module combo_bist_ctrl import combo_bist_pkg::*; #(
  parameter int                   N_IN      = N_IN_DEF,
  parameter int                   SETTLE    = 1,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 32'hFFFF_FFFE
) (
  input  logic              clk,
  input  logic              rst_n,
  combo_bist_ctrl_if.master bus
);

  // The counter is loaded with SETTLE-1 so WAIT spans exactly SETTLE cycles before zero.
  localparam bit                  HAS_WAIT    = (SETTLE > 0);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = HAS_WAIT ? SETTLE_W'(SETTLE - 1) : '0;
  localparam logic [N_IN-1:0]     LAST_VEC    = '1;

  state_t                 state_q;
  state_t                 state_d;
  logic [N_IN-1:0]        vec;
  logic [(1<<N_IN)-1:0]   tt;
  logic [N_IN:0]          fail_cnt;
  logic [N_IN:0]          fail_next;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic                   mismatch;
  logic                   accept;
  logic                   leave;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;

  assign mismatch  = (bus.z != EXP_TABLE[vec]);
  assign fail_next = fail_cnt + (N_IN+1)'(mismatch);
  assign accept    = (state_d == APPLY) && ((state_q == IDLE) || (state_q == DONE));
  assign leave     = (state_d == IDLE) && (state_q != IDLE);

  combo_bist_settle_cnt u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (leave),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) state_d = APPLY;
      end
      APPLY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (HAS_WAIT) begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end else begin
          state_d = SAMPLE;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (vec == LAST_VEC) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An abort keeps tt/fail_cnt as partial results; only an accepted start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      tt       <= '0;
      fail_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else if (accept) begin
      vec      <= '0;
      tt       <= '0;
      fail_cnt <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else if (leave) begin
      vec  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state_q == SAMPLE) begin
      tt[vec]  <= bus.z;
      fail_cnt <= fail_next;
      if (vec == LAST_VEC) begin
        vec  <= '0;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (fail_next == '0);
      end else begin
        vec <= vec + 1'b1;
      end
    end
  end

`ifdef COMBO_BIST_FAILIDX_EN
  logic [N_IN-1:0] fail_idx;
  logic            fail_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_idx  <= '0;
      fail_seen <= 1'b0;
    end else if (accept) begin
      fail_idx  <= '0;
      fail_seen <= 1'b0;
    end else if ((state_q == SAMPLE) && !bus.abort && mismatch && !fail_seen) begin
      fail_idx  <= vec;
      fail_seen <= 1'b1;
    end
  end

  assign bus.fail_idx  = fail_idx;
  assign bus.fail_seen = fail_seen;
`endif

  assign bus.vec      = vec;
  assign bus.tt       = tt;
  assign bus.fail_cnt = fail_cnt;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;

endmodule

// File: tb/tb_combo_bist_ctrl.sv
// Self-checking bench: two sequencers (SETTLE=1 and SETTLE=0) sweep an OR-gate model with injected faults.
`timescale 1ns/1ps
module tb_combo_bist_ctrl;

  localparam int               NI    = 5;
  localparam int               DEPTH = 1 << NI;
  localparam logic [DEPTH-1:0] GOLD  = 32'hFFFF_FFFE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_req;
  logic             abort_req;
  logic             sel;
  logic [DEPTH-1:0] fault_mask;
  int               tests_run = 0;
  int               tests_failed = 0;

  always #5 clk = ~clk;

  combo_bist_ctrl_if #(.N_IN(NI)) bus0 ();
  combo_bist_ctrl_if #(.N_IN(NI)) bus1 ();

  assign bus0.start = start_req & ~sel;
  assign bus0.abort = abort_req & ~sel;
  assign bus1.start = start_req & sel;
  assign bus1.abort = abort_req & sel;

  // Gate under test: a 5-input OR, with selected rows inverted to emulate faults.
  assign bus0.z = (bus0.vec != '0) ^ fault_mask[bus0.vec];
  assign bus1.z = (bus1.vec != '0) ^ fault_mask[bus1.vec];

  combo_bist_ctrl #(.N_IN(NI), .SETTLE(1), .EXP_TABLE(GOLD)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  combo_bist_ctrl #(.N_IN(NI), .SETTLE(0), .EXP_TABLE(GOLD)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic             obs_busy;
  logic             obs_done;
  logic             obs_pass;
  logic [NI-1:0]    obs_vec;
  logic [DEPTH-1:0] obs_tt;
  logic [NI:0]      obs_fail;
  assign obs_busy = sel ? bus1.busy     : bus0.busy;
  assign obs_done = sel ? bus1.done     : bus0.done;
  assign obs_pass = sel ? bus1.pass     : bus0.pass;
  assign obs_vec  = sel ? bus1.vec      : bus0.vec;
  assign obs_tt   = sel ? bus1.tt       : bus0.tt;
  assign obs_fail = sel ? bus1.fail_cnt : bus0.fail_cnt;
`ifdef COMBO_BIST_FAILIDX_EN
  logic [NI-1:0]    obs_fidx;
  logic             obs_fseen;
  assign obs_fidx  = sel ? bus1.fail_idx  : bus0.fail_idx;
  assign obs_fseen = sel ? bus1.fail_seen : bus0.fail_seen;
`endif

  // Reference model: truth table the gate actually exhibits, then compared with the golden table.
  function automatic logic [DEPTH-1:0] model_tt(input logic [DEPTH-1:0] mask);
    logic [DEPTH-1:0] t;
    for (int i = 0; i < DEPTH; i++) t[i] = (i != 0) ^ mask[i];
    return t;
  endfunction

  function automatic int model_fails(input logic [DEPTH-1:0] mask);
    return $countones(model_tt(mask) ^ GOLD);
  endfunction

  function automatic int model_first(input logic [DEPTH-1:0] mask);
    for (int i = 0; i < DEPTH; i++) if (model_tt(mask)[i] != GOLD[i]) return i;
    return 0;
  endfunction

  function automatic int sweep_len(input logic s);
    return DEPTH * ((s ? 0 : 1) + 2);
  endfunction

  task automatic run_sweep(input int restart_at, output int cycles, output int busy_cycles,
                           output bit vec_ok, output int vec_max);
    int prev;
    bit pulsed;
    pulsed = 0;
    @(negedge clk);
    start_req = 1'b1;
    @(posedge clk); #1;
    start_req   = 1'b0;
    cycles      = 0;
    busy_cycles = obs_busy ? 1 : 0;
    vec_ok      = (obs_vec == '0);
    prev        = 0;
    vec_max     = 0;
    while (!obs_done && cycles < 1000) begin
      @(posedge clk); #1;
      start_req = 1'b0;
      cycles++;
      if (obs_busy) begin
        busy_cycles++;
        if (!(int'(obs_vec) == prev || int'(obs_vec) == prev + 1)) vec_ok = 0;
        prev = int'(obs_vec);
        if (prev > vec_max) vec_max = prev;
        if (restart_at >= 0 && prev == restart_at && !pulsed) begin
          start_req = 1'b1;
          pulsed    = 1;
        end
      end
    end
  endtask

  task automatic wait_vec(input int target);
    int n;
    n = 0;
    while (int'(obs_vec) != target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (int'(obs_vec) != target) begin
      tests_failed++;
      $display("[TB] FAIL wait_vec: got vec=%0d required %0d within 500 cycles", obs_vec, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_req = 1'b0; abort_req = 1'b0; sel = 1'b0; fault_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      tests_run++;
      if ({bus0.busy, bus0.done, bus0.pass, bus1.busy, bus1.done, bus1.pass} !== 6'b0 ||
          bus0.vec !== '0 || bus1.vec !== '0 || bus0.tt !== '0 || bus1.tt !== '0 ||
          bus0.fail_cnt !== '0 || bus1.fail_cnt !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs: got busy=%b/%b done=%b/%b pass=%b/%b vec=%0h/%0h tt=%0h/%0h fc=%0d/%0d required all 0",
                 bus0.busy, bus1.busy, bus0.done, bus1.done, bus0.pass, bus1.pass,
                 bus0.vec, bus1.vec, bus0.tt, bus1.tt, bus0.fail_cnt, bus1.fail_cnt);
      end
`ifdef COMBO_BIST_FAILIDX_EN
      tests_run++;
      if (bus0.fail_idx !== '0 || bus0.fail_seen !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_failidx: got idx=%0d seen=%b required 0/0", bus0.fail_idx, bus0.fail_seen);
      end
`endif
    end
  endtask

  // Shared by the clean and single-fault scenarios; restart_at exercises start-while-busy.
  task automatic test_sweep(input string name, input logic s, input logic [DEPTH-1:0] mask,
                            input int restart_at);
    int cyc, bcyc, vmax;
    bit vok;
    sel = s;
    fault_mask = mask;
    run_sweep(restart_at, cyc, bcyc, vok, vmax);
    tests_run++;
    if (cyc != sweep_len(s) || bcyc != sweep_len(s)) begin
      tests_failed++;
      $display("[TB] FAIL %s_length: got done after %0d busy %0d required %0d", name, cyc, bcyc, sweep_len(s));
    end
    tests_run++;
    if (!vok || vmax != DEPTH - 1) begin
      tests_failed++;
      $display("[TB] FAIL %s_vec_steps: got ok=%0b max=%0d required ok=1 max=%0d", name, vok, vmax, DEPTH - 1);
    end
    tests_run++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_vec !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s_done_state: got done=%b busy=%b vec=%0d required 1/0/0", name, obs_done, obs_busy, obs_vec);
    end
    tests_run++;
    if (obs_tt !== model_tt(mask)) begin
      tests_failed++;
      $display("[TB] FAIL %s_tt: got %h required %h", name, obs_tt, model_tt(mask));
    end
    tests_run++;
    if (int'(obs_fail) != model_fails(mask) || obs_pass !== (model_fails(mask) == 0)) begin
      tests_failed++;
      $display("[TB] FAIL %s_verdict: got fail_cnt=%0d pass=%b required %0d/%b", name, obs_fail, obs_pass,
               model_fails(mask), model_fails(mask) == 0);
    end
`ifdef COMBO_BIST_FAILIDX_EN
    tests_run++;
    if (obs_fseen !== (model_fails(mask) != 0) || int'(obs_fidx) != model_first(mask)) begin
      tests_failed++;
      $display("[TB] FAIL %s_failidx: got idx=%0d seen=%b required %0d/%b", name, obs_fidx, obs_fseen,
               model_first(mask), model_fails(mask) != 0);
    end
`endif
  endtask

  task automatic test_fault_vec7();
    logic [DEPTH-1:0] m;
    m = '0;
    m[7] = 1'b1;
    test_sweep("fault7", 1'b0, m, -1);
    tests_run++;
    if (obs_tt !== 32'hFFFF_FF7E || obs_fail !== 6'd1) begin
      tests_failed++;
      $display("[TB] FAIL fault7_const: got tt=%h fc=%0d required ffffff7e/1", obs_tt, obs_fail);
    end
  endtask

  task automatic test_abort();
    sel = 1'b0;
    fault_mask = '0;
    @(negedge clk);
    start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    wait_vec(10);
    abort_req = 1'b1;
    @(posedge clk); #1;
    abort_req = 1'b0;
    tests_run++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_pass !== 1'b0 || obs_vec !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: got busy=%b done=%b pass=%b vec=%0d required 0/0/0/0",
               obs_busy, obs_done, obs_pass, obs_vec);
    end
    tests_run++;
    if (obs_tt !== (model_tt('0) & DEPTH'(32'h3FF)) || obs_fail !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_partial: got tt=%h fc=%0d required %h/0", obs_tt, obs_fail,
               model_tt('0) & DEPTH'(32'h3FF));
    end
    test_sweep("after_abort", 1'b0, '0, -1);
  endtask

  task automatic test_start_abort_idle();
    sel = 1'b0;
    @(negedge clk);
    abort_req = 1'b1;
    @(posedge clk); #1;
    abort_req = 1'b0;
    @(negedge clk);
    start_req = 1'b1;
    abort_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    abort_req = 1'b0;
    repeat (3) begin
      tests_run++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL start_abort_idle: got busy=%b done=%b required 0/0", obs_busy, obs_done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midsweep();
    sel = 1'b1;
    fault_mask = '0;
    @(negedge clk);
    start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    wait_vec(20);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.pass !== 1'b0 || bus1.vec !== '0 ||
        bus1.tt !== '0 || bus1.fail_cnt !== '0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b pass=%b vec=%0d tt=%h fc=%0d required all 0",
               bus1.busy, bus1.done, bus1.pass, bus1.vec, bus1.tt, bus1.fail_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus1.busy !== 1'b0 || bus1.vec !== '0) begin
      tests_failed++;
      $display("[TB] FAIL no_resume: got busy=%b vec=%0d required 0/0", bus1.busy, bus1.vec);
    end
    test_sweep("settle0", 1'b1, '0, -1);
  endtask

  task automatic test_random();
    logic [DEPTH-1:0] m;
    for (int k = 0; k < 8; k++) begin
      m = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0) m = '0;
      test_sweep("random", 1'($urandom_range(0, 1)), m, -1);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("or_clean", 1'b0, '0, -1);
    test_fault_vec7();
    test_abort();
    test_start_abort_idle();
    test_sweep("restart_busy", 1'b0, '0, 3);
    test_reset_midsweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
